temporizador_bcd: RTL and testbench
===================================

TEMPORIZADOR_BCD -- requirements
Module: temporizador_bcd

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, system clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port `reset`: input, 1 bit, asynchronous, active-high; it clears all state immediately.
REQ-003 The block SHALL have the port `tick`: input, 1 bit, one-`clk`-cycle strobe once per second (countdown enable).
REQ-004 The block SHALL have the port `mag_on`: input, 1 bit, magnetron active, from the magnetron control stage; high enables countdown and blocks entry.
REQ-005 The block SHALL have the port `clearn`: input, 1 bit, active-low synchronous clear of time and entry count.
REQ-006 The block SHALL have the port `key_valid`: input, 1 bit, one-cycle strobe qualifying `key_code`.
REQ-007 The block SHALL have the port `key_code`: input, 4 bits, keypad digit; only values 0-9 are legal.
REQ-008 The block SHALL have the ports `min_tens`, `min_units`, `sec_tens` and `sec_units`: outputs, 4 bits each, BCD time display in the form MM:SS.
REQ-009 The block SHALL have the port `digit_cnt`: output, 3 bits, number of digits entered since the last clear (0-4).
REQ-010 The block SHALL have the port `timer_done`: output, 1 bit, high whenever all four digits are 0; it drives `timer_done` of the magnetron control stage.
REQ-011 Clock and reset SHALL be exactly one clock, `clk`, and one asynchronous, active-high reset, `reset`; there are no other clock or reset inputs.

Function
REQ-012 Each `clk` edge SHALL apply at most one action, in this priority order: `clearn`=0, then countdown, then key entry.
REQ-013 When `clearn`=0, the next edge SHALL set all digits and `digit_cnt` to 0, regardless of `mag_on`, `tick` or `key_valid`.
REQ-014 Key entry SHALL occur only when `key_valid`=1, `mag_on`=0, `key_code`<=9 and `digit_cnt`<4.
REQ-015 A key entry SHALL shift the digits left (`min_tens`<=`min_units`, `min_units`<=`sec_tens`, `sec_tens`<=`sec_units`, `sec_units`<=`key_code`) and increment `digit_cnt`.
REQ-016 A key with `key_code`>9, a fifth key, or a key arriving while `mag_on`=1 SHALL be ignored: no digit or `digit_cnt` change.
REQ-017 Countdown SHALL occur only when `tick`=1, `mag_on`=1 and the time is nonzero, decrementing the time by one second per tick.
REQ-018 Countdown SHALL update the digits on the same edge that samples `tick`=1, with no further latency.
REQ-019 Borrow rule: `sec_units` 0 SHALL become 9 and borrow from `sec_tens`.
REQ-020 Borrow rule: `sec_tens` 0 under borrow SHALL become 5 and borrow from `min_units`.
REQ-021 Borrow rule: `min_units` 0 under borrow SHALL become 9 and borrow from `min_tens`.
REQ-022 An entered `sec_tens` of 6-9 SHALL decrement normally (e.g. 0:99 counts down to 0:98) and SHALL NOT be normalised.
REQ-023 At 00:00, a `tick` SHALL cause no change: no wrap to 99:59 and no underflow.
REQ-024 `timer_done` SHALL be a combinational decode of the digit registers, with zero cycles of latency from the digits reaching 00:00.
REQ-025 Time reaching 00:00 by countdown SHALL leave `digit_cnt` unchanged; only a clear or a reset zeroes `digit_cnt`.
REQ-026 The `mag_on` level SHALL have effect only at clock edges; there is no internal latching of `mag_on`.

Reset
REQ-027 While `reset`=1, all digits SHALL be 0, `digit_cnt` SHALL be 0, and `timer_done` SHALL be 1, independent of `clk`.
REQ-028 A reset asserted mid-countdown or mid-entry SHALL abort the operation immediately, with no partial update.
REQ-029 After `reset` deasserts, the first edge SHALL behave per REQ-012 to REQ-026.

Verification
REQ-030 Reset/idle scenario: release `reset` -> all digits 0, `digit_cnt`=0, `timer_done`=1; pulse `tick` with `mag_on`=1 -> no change.
REQ-031 Entry scenario: keys 1, 3, 0, 5 with `mag_on`=0 -> display 13:05, `digit_cnt`=4, `timer_done`=0; a fifth key 7 -> unchanged; key 12 -> ignored.
REQ-032 Borrow chain scenario: entry 1,0,0,0 (10:00), then `mag_on`=1 and one tick -> 09:59; entry 0:01 and one tick -> 00:00, `timer_done`=1; a further tick -> stays at 00:00.
REQ-033 Simultaneous-events scenario: `mag_on`=1 with `tick` and `key_valid` on the same edge -> only the decrement occurs; `clearn`=0 together with `tick` -> 00:00 and `digit_cnt`=0.
REQ-034 Mid-run abort scenario: during countdown, drop `mag_on` -> display holds; assert `reset` asynchronously between edges -> outputs reach 0 before the next edge.

Source files
------------

// File: rtl/temporizador_bcd.sv
// temporizador_bcd: MM:SS BCD countdown timer with keypad digit entry and a done flag.
module temporizador_bcd (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mag_on,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic [2:0] digit_cnt,
  output logic       timer_done
);
  logic [3:0] mt_q, mu_q, st_q, su_q, mt_d, mu_d, st_d, su_d;
  logic [3:0] mt_dec, mu_dec, st_dec, su_dec;
  logic [2:0] cnt_q, cnt_d;
  logic       zero, su_b, st_b, mu_b, do_dec, do_key;
  assign zero = ~|{mt_q, mu_q, st_q, su_q};
  // Borrow chain: sec_units wraps to 9, sec_tens to 5, min_units to 9; min_tens cannot underflow while time is nonzero.
  assign su_b   = su_q == 4'd0;
  assign st_b   = su_b && st_q == 4'd0;
  assign mu_b   = st_b && mu_q == 4'd0;
  assign su_dec = su_b ? 4'd9 : su_q - 4'd1;
  assign st_dec = su_b ? (st_q == 4'd0 ? 4'd5 : st_q - 4'd1) : st_q;
  assign mu_dec = st_b ? (mu_q == 4'd0 ? 4'd9 : mu_q - 4'd1) : mu_q;
  assign mt_dec = mu_b ? mt_q - 4'd1 : mt_q;
  assign do_dec = tick && mag_on && !zero;
  assign do_key = key_valid && !mag_on && key_code <= 4'd9 && cnt_q < 3'd4;
  always_comb begin
    mt_d  = mt_q;
    mu_d  = mu_q;
    st_d  = st_q;
    su_d  = su_q;
    cnt_d = cnt_q;
    if (!clearn) begin
      {mt_d, mu_d, st_d, su_d} = 16'h0000;
      cnt_d = 3'd0;
    end else if (do_dec) begin
      {mt_d, mu_d, st_d, su_d} = {mt_dec, mu_dec, st_dec, su_dec};
    end else if (do_key) begin
      {mt_d, mu_d, st_d, su_d} = {mu_q, st_q, su_q, key_code};
      cnt_d = cnt_q + 3'd1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mt_q  <= 4'd0;
      mu_q  <= 4'd0;
      st_q  <= 4'd0;
      su_q  <= 4'd0;
      cnt_q <= 3'd0;
    end else begin
      mt_q  <= mt_d;
      mu_q  <= mu_d;
      st_q  <= st_d;
      su_q  <= su_d;
      cnt_q <= cnt_d;
    end
  end
  assign min_tens   = mt_q;
  assign min_units  = mu_q;
  assign sec_tens   = st_q;
  assign sec_units  = su_q;
  assign digit_cnt  = cnt_q;
  assign timer_done = zero;
endmodule

// File: tb/tb_temporizador_bcd.sv
// tb_temporizador_bcd: directed vector table plus async-reset sequences for temporizador_bcd.
module tb_temporizador_bcd;
  logic       clk = 1'b0, reset = 1'b0, tick = 1'b0, mag_on = 1'b0, clearn = 1'b1, key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [3:0] min_tens, min_units, sec_tens, sec_units;
  logic [2:0] digit_cnt;
  logic       timer_done;
  int errors = 0, checks = 0;
  typedef struct {
    logic        clearn, tick, mag, kv;
    logic [3:0]  kc;
    logic [15:0] t;
    logic [2:0]  cnt;
    logic        done;
  } vec_t;
  vec_t v[$];
  temporizador_bcd dut (
    .clk(clk), .reset(reset), .tick(tick), .mag_on(mag_on), .clearn(clearn),
    .key_valid(key_valid), .key_code(key_code), .min_tens(min_tens), .min_units(min_units),
    .sec_tens(sec_tens), .sec_units(sec_units), .digit_cnt(digit_cnt), .timer_done(timer_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string name, input logic [15:0] t, input logic [2:0] cnt, input logic done);
    chk({name, ".time"}, {16'h0, min_tens, min_units, sec_tens, sec_units}, {16'h0, t});
    chk({name, ".cnt"}, {29'h0, digit_cnt}, {29'h0, cnt});
    chk({name, ".done"}, {31'h0, timer_done}, {31'h0, done});
  endtask
  task automatic add(input logic c, input logic tk, input logic m, input logic k, input logic [3:0] kc,
                     input logic [15:0] t, input logic [2:0] cnt, input logic done);
    vec_t e;
    e.clearn = c; e.tick = tk; e.mag = m; e.kv = k; e.kc = kc; e.t = t; e.cnt = cnt; e.done = done;
    v.push_back(e);
  endtask
  task automatic step(input logic c, input logic tk, input logic m, input logic k, input logic [3:0] kc);
    @(negedge clk);
    clearn = c; tick = tk; mag_on = m; key_valid = k; key_code = kc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    add(1, 1, 1, 0, 0, 16'h0000, 0, 1);
    add(1, 0, 0, 1, 1, 16'h0001, 1, 0);
    add(1, 0, 0, 1, 3, 16'h0013, 2, 0);
    add(1, 0, 0, 1, 0, 16'h0130, 3, 0);
    add(1, 0, 0, 1, 5, 16'h1305, 4, 0);
    add(1, 0, 0, 1, 7, 16'h1305, 4, 0);
    add(1, 0, 0, 1, 12, 16'h1305, 4, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 0, 1);
    add(1, 0, 0, 1, 12, 16'h0000, 0, 1);
    add(1, 0, 0, 1, 1, 16'h0001, 1, 0);
    add(1, 0, 0, 1, 0, 16'h0010, 2, 0);
    add(1, 0, 0, 1, 0, 16'h0100, 3, 0);
    add(1, 0, 0, 1, 0, 16'h1000, 4, 0);
    add(1, 1, 0, 0, 0, 16'h1000, 4, 0);
    add(1, 1, 1, 0, 0, 16'h0959, 4, 0);
    add(1, 0, 1, 1, 3, 16'h0959, 4, 0);
    add(1, 1, 1, 1, 4, 16'h0958, 4, 0);
    add(1, 1, 1, 0, 0, 16'h0957, 4, 0);
    add(1, 1, 0, 0, 0, 16'h0957, 4, 0);
    add(0, 1, 1, 1, 2, 16'h0000, 0, 1);
    add(1, 0, 0, 1, 0, 16'h0000, 1, 1);
    add(1, 0, 0, 1, 0, 16'h0000, 2, 1);
    add(1, 0, 0, 1, 0, 16'h0000, 3, 1);
    add(1, 0, 0, 1, 1, 16'h0001, 4, 0);
    add(1, 1, 1, 0, 0, 16'h0000, 4, 1);
    add(1, 1, 1, 0, 0, 16'h0000, 4, 1);
    add(0, 0, 0, 0, 0, 16'h0000, 0, 1);
    add(1, 0, 0, 1, 0, 16'h0000, 1, 1);
    add(1, 0, 0, 1, 0, 16'h0000, 2, 1);
    add(1, 0, 0, 1, 9, 16'h0009, 3, 0);
    add(1, 0, 0, 1, 9, 16'h0099, 4, 0);
    add(1, 1, 1, 0, 0, 16'h0098, 4, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 0, 1);
    add(1, 0, 0, 1, 1, 16'h0001, 1, 0);
    add(1, 0, 0, 1, 0, 16'h0010, 2, 0);
    add(1, 0, 0, 1, 0, 16'h0100, 3, 0);
    add(1, 1, 1, 0, 0, 16'h0059, 3, 0);
    add(1, 0, 0, 1, 2, 16'h0592, 4, 0);
    #2 reset = 1'b1;
    #1 chk_all("reset_async", 16'h0000, 0, 1);
    step(1, 1, 1, 1, 5);
    chk_all("reset_held", 16'h0000, 0, 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].clearn, v[i].tick, v[i].mag, v[i].kv, v[i].kc);
      chk_all($sformatf("vec%0d", i), v[i].t, v[i].cnt, v[i].done);
    end
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 2);
    step(1, 0, 0, 1, 3);
    step(1, 1, 1, 0, 0);
    chk_all("pre_abort", 16'h0022, 2, 0);
    @(negedge clk);
    tick = 1'b1;
    #2 reset = 1'b1;
    #1 chk_all("abort_async", 16'h0000, 0, 1);
    @(posedge clk);
    #1 chk_all("abort_edge", 16'h0000, 0, 1);
    @(negedge clk);
    reset = 1'b0;
    step(1, 1, 1, 0, 0);
    chk_all("post_reset_tick", 16'h0000, 0, 1);
    step(1, 0, 0, 1, 8);
    chk_all("post_reset_key", 16'h0008, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
